// File: rtl/mem_word_port.sv
// mem_word_port
//
// Turns one 16-bit word request into two back-to-back byte accesses on an
// 8-bit synchronous data memory. A word read assembles two bytes into RData,
// a word write splits WData into two bytes. Handshake is Start/Busy/Done.
//
// Parameters:
//   BIG_ENDIAN  0: low byte at Address, high byte at Address+1
//               1: high byte at Address, low byte at Address+1
//
// Ports:
//   Clock     in   1   rising-edge clock
//   Reset     in   1   asynchronous, active-low reset
//   Start     in   1   request strobe, only sampled while idle
//   Write     in   1   1 = word write, 0 = word read (sampled with Start)
//   Address   in  16   word base address (sampled with Start)
//   WData     in  16   write data (sampled with Start)
//   RData     out 16   registered read result, held until the next read ends
//   Busy      out  1   high while a transaction is in progress
//   Done      out  1   registered one-cycle completion pulse
//   MemCS     out  1   memory chip select
//   MemWE     out  1   memory write enable (only with MemCS)
//   MemAddr   out 16   byte address
//   MemWData  out  8   byte write data
//   MemRData  in   8   byte read data, valid the cycle after a read select

module mem_word_port #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Write,
    input  logic [15:0] Address,
    input  logic [15:0] WData,
    output logic [15:0] RData,
    output logic        Busy,
    output logic        Done,
    output logic        MemCS,
    output logic        MemWE,
    output logic [15:0] MemAddr,
    output logic [7:0]  MemWData,
    input  logic [7:0]  MemRData
);

    typedef enum logic [1:0] {
        IDLE,
        B0,
        B1,
        CAP
    } state_t;

    state_t      state;
    state_t      nextState;

    logic [15:0] addrLatch;
    logic        writeLatch;
    logic [15:0] dataLatch;
    logic [7:0]  firstByte;

    logic [7:0]  firstWriteByte;
    logic [7:0]  secondWriteByte;

    // The byte that goes to the base address depends on the byte order.
    assign firstWriteByte  = BIG_ENDIAN ? dataLatch[15:8] : dataLatch[7:0];
    assign secondWriteByte = BIG_ENDIAN ? dataLatch[7:0]  : dataLatch[15:8];

    assign Busy = (state != IDLE);

    // State register, request latches, read assembly and the Done pulse.
    // The memory answers one cycle after it is selected, so the byte from
    // the base address arrives during B1 and the byte from Address+1
    // arrives during CAP; the word is assembled straight from MemRData at
    // the end of CAP so RData and Done appear together in the next cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            addrLatch  <= 16'h0000;
            writeLatch <= 1'b0;
            dataLatch  <= 16'h0000;
            firstByte  <= 8'h00;
            RData      <= 16'h0000;
            Done       <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && Start) begin
                addrLatch  <= Address;
                writeLatch <= Write;
                dataLatch  <= WData;
            end
            if (state == B1 && !writeLatch) begin
                firstByte <= MemRData;
            end
            if (state == CAP) begin
                RData <= BIG_ENDIAN ? {firstByte, MemRData} : {MemRData, firstByte};
            end
            Done <= (state == B1 && writeLatch) || (state == CAP);
        end
    end

    // Next-state logic and memory bus drive. The bus is forced to zero
    // whenever the chip select is low so idle cycles are easy to recognise.
    // The +1 on the address wraps naturally within 16 bits.
    always_comb begin
        nextState = state;
        MemCS     = 1'b0;
        MemWE     = 1'b0;
        MemAddr   = 16'h0000;
        MemWData  = 8'h00;
        case (state)
            IDLE: begin
                if (Start) begin
                    nextState = B0;
                end
            end
            B0: begin
                MemCS     = 1'b1;
                MemWE     = writeLatch;
                MemAddr   = addrLatch;
                MemWData  = firstWriteByte;
                nextState = B1;
            end
            B1: begin
                MemCS     = 1'b1;
                MemWE     = writeLatch;
                MemAddr   = addrLatch + 16'd1;
                MemWData  = secondWriteByte;
                nextState = writeLatch ? IDLE : CAP;
            end
            CAP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_word_port.sv
// tb_mem_word_port
//
// Bench for mem_word_port. Two instances are used: one little-endian and one
// big-endian, each with its own byte-wide synchronous memory model. Requests
// push their expected RData and latency into a scoreboard queue; a monitor
// pops and compares every time a Done pulse appears.

module tb_mem_word_port;

    typedef struct {
        int          sel;
        logic [15:0] rdata;
        int          startCycle;
        int          latency;
    } ExpEntry;

    logic        clock = 1'b0;
    logic        resetN;

    logic        startLe, writeLe, busyLe, doneLe, memCsLe, memWeLe;
    logic [15:0] addressLe, wdataLe, rdataLe, memAddrLe;
    logic [7:0]  memWDataLe, memRDataLe;

    logic        startBe, writeBe, busyBe, doneBe, memCsBe, memWeBe;
    logic [15:0] addressBe, wdataBe, rdataBe, memAddrBe;
    logic [7:0]  memWDataBe, memRDataBe;

    logic [7:0]  memLe [0:65535];
    logic [7:0]  memBe [0:65535];
    logic [15:0] addrLogLe[$];

    ExpEntry     scoreboard[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          doneCount = 0;

    always #5 clock = ~clock;

    // Cycle index, advanced on every active edge.
    always @(posedge clock) begin
        cyc <= cyc + 1;
    end

    mem_word_port #(.BIG_ENDIAN(1'b0)) dutLe (
        .Clock(clock), .Reset(resetN), .Start(startLe), .Write(writeLe),
        .Address(addressLe), .WData(wdataLe), .RData(rdataLe), .Busy(busyLe),
        .Done(doneLe), .MemCS(memCsLe), .MemWE(memWeLe), .MemAddr(memAddrLe),
        .MemWData(memWDataLe), .MemRData(memRDataLe)
    );

    mem_word_port #(.BIG_ENDIAN(1'b1)) dutBe (
        .Clock(clock), .Reset(resetN), .Start(startBe), .Write(writeBe),
        .Address(addressBe), .WData(wdataBe), .RData(rdataBe), .Busy(busyBe),
        .Done(doneBe), .MemCS(memCsBe), .MemWE(memWeBe), .MemAddr(memAddrBe),
        .MemWData(memWDataBe), .MemRData(memRDataBe)
    );

    // Synchronous byte memories: write on a selected write, read data is
    // registered and so appears the cycle after a selected read.
    always @(posedge clock) begin
        if (memCsLe) begin
            addrLogLe.push_back(memAddrLe);
            if (memWeLe) memLe[memAddrLe] <= memWDataLe;
            else         memRDataLe <= memLe[memAddrLe];
        end
    end

    always @(posedge clock) begin
        if (memCsBe) begin
            if (memWeBe) memBe[memAddrBe] <= memWDataBe;
            else         memRDataBe <= memBe[memAddrBe];
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic doneOf(input int sel);
        return (sel != 0) ? doneBe : doneLe;
    endfunction

    // Monitor side of the scoreboard: every Done must match the oldest
    // outstanding request for that instance.
    task automatic checkDone(input int sel);
        ExpEntry e;
        doneCount++;
        if (scoreboard.size() == 0 || scoreboard[0].sel != sel) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected Done on instance %0d at cycle %0d", sel, cyc);
        end else begin
            e = scoreboard.pop_front();
            checkOutput("rdata", (sel != 0) ? rdataBe : rdataLe, e.rdata);
            checkOutput("latency", 16'(cyc - e.startCycle), 16'(e.latency));
        end
    endtask

    always @(negedge clock) begin
        if (resetN) begin
            if (doneLe) checkDone(0);
            if (doneBe) checkDone(1);
        end
    end

    // Drives a request during the current cycle and records what the
    // matching Done must show. Called right at a falling edge.
    task automatic applyStimulus(input int sel, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] data, input logic [15:0] expRData);
        ExpEntry e;
        e.sel        = sel;
        e.rdata      = expRData;
        e.startCycle = cyc;
        e.latency    = wr ? 3 : 4;
        scoreboard.push_back(e);
        if (sel != 0) begin
            startBe = 1'b1; writeBe = wr; addressBe = addr; wdataBe = data;
        end else begin
            startLe = 1'b1; writeLe = wr; addressLe = addr; wdataLe = data;
        end
    endtask

    task automatic releaseStart(input int sel);
        if (sel != 0) startBe = 1'b0;
        else          startLe = 1'b0;
    endtask

    task automatic waitDone(input int sel);
        int n = 0;
        while (!doneOf(sel) && n < 12) begin
            @(negedge clock);
            n++;
        end
        if (!doneOf(sel)) begin
            checks++;
            errors++;
            $display("[TB] FAIL done timeout on instance %0d: got no Done, expected one within 12 cycles", sel);
        end
    endtask

    task automatic doTransaction(input int sel, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] data, input logic [15:0] expRData);
        applyStimulus(sel, wr, addr, data, expRData);
        @(negedge clock);
        releaseStart(sel);
        waitDone(sel);
        @(negedge clock);
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] snap40;
        logic [7:0] snap41;
        int         doneBase;

        resetN  = 1'b0;
        startLe = 1'b0; writeLe = 1'b0; addressLe = 16'h0000; wdataLe = 16'h0000;
        startBe = 1'b0; writeBe = 1'b0; addressBe = 16'h0000; wdataBe = 16'h0000;

        // Reset state.
        repeat (2) @(negedge clock);
        checkOutput("reset rdata", rdataLe, 16'h0000);
        checkOutput("reset busy", {15'd0, busyLe}, 16'h0000);
        checkOutput("reset done", {15'd0, doneLe}, 16'h0000);
        checkOutput("reset memcs", {15'd0, memCsLe}, 16'h0000);
        resetN = 1'b1;
        repeat (2) @(negedge clock);

        // Little-endian write, then read back.
        doTransaction(0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        checkOutput("le mem 0010", {8'h00, memLe[16'h0010]}, 16'h00EF);
        checkOutput("le mem 0011", {8'h00, memLe[16'h0011]}, 16'h00BE);
        doTransaction(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

        // Reset asserted while a read sits in B1.
        applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        @(negedge clock);
        releaseStart(0);
        @(negedge clock);
        checkOutput("b1 memaddr", memAddrLe, 16'h0011);
        resetN = 1'b0;
        #1;
        scoreboard.delete();
        checkOutput("abort busy", {15'd0, busyLe}, 16'h0000);
        checkOutput("abort done", {15'd0, doneLe}, 16'h0000);
        checkOutput("abort memcs", {15'd0, memCsLe}, 16'h0000);
        checkOutput("abort memwe", {15'd0, memWeLe}, 16'h0000);
        checkOutput("abort memaddr", memAddrLe, 16'h0000);
        checkOutput("abort memwdata", {8'h00, memWDataLe}, 16'h0000);
        checkOutput("abort rdata", rdataLe, 16'h0000);
        @(negedge clock);
        resetN = 1'b1;
        repeat (6) @(negedge clock);

        // Address wrap-around on a write.
        addrLogLe.delete();
        doTransaction(0, 1'b1, 16'hFFFF, 16'hA55A, 16'h0000);
        checkOutput("wrap addr count", 16'(addrLogLe.size()), 16'd2);
        if (addrLogLe.size() == 2) begin
            checkOutput("wrap addr first", addrLogLe[0], 16'hFFFF);
            checkOutput("wrap addr second", addrLogLe[1], 16'h0000);
        end
        checkOutput("wrap mem ffff", {8'h00, memLe[16'hFFFF]}, 16'h005A);
        checkOutput("wrap mem 0000", {8'h00, memLe[16'h0000]}, 16'h00A5);

        // Start pulsed again while busy must be ignored.
        snap40   = memLe[16'h0040];
        snap41   = memLe[16'h0041];
        doneBase = doneCount;
        applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        @(negedge clock);
        releaseStart(0);
        @(negedge clock);
        startLe = 1'b1; writeLe = 1'b1; addressLe = 16'h0040; wdataLe = 16'h7777;
        @(negedge clock);
        startLe = 1'b0;
        waitDone(0);
        repeat (5) @(negedge clock);
        checkOutput("busy start done count", 16'(doneCount - doneBase), 16'd1);
        checkOutput("busy start mem 0040", {8'h00, memLe[16'h0040]}, {8'h00, snap40});
        checkOutput("busy start mem 0041", {8'h00, memLe[16'h0041]}, {8'h00, snap41});

        // Back-to-back reads, each issued in the previous Done cycle.
        doTransaction(0, 1'b1, 16'h0010, 16'h2211, 16'hBEEF);
        doTransaction(0, 1'b1, 16'h0012, 16'h4433, 16'hBEEF);
        checkOutput("b2b busy c0", {15'd0, busyLe}, 16'h0000);
        applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 16'h2211);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1 || k == 5) releaseStart(0);
            checkOutput($sformatf("b2b busy c%0d", k), {15'd0, busyLe},
                        (k == 4 || k == 8) ? 16'h0000 : 16'h0001);
            if (k == 4) applyStimulus(0, 1'b0, 16'h0012, 16'h0000, 16'h4433);
        end
        @(negedge clock);

        // Big-endian write and read back.
        doTransaction(1, 1'b1, 16'h0020, 16'h1234, 16'h0000);
        checkOutput("be mem 0020", {8'h00, memBe[16'h0020]}, 16'h0012);
        checkOutput("be mem 0021", {8'h00, memBe[16'h0021]}, 16'h0034);
        doTransaction(1, 1'b0, 16'h0020, 16'h0000, 16'h1234);

        repeat (4) @(negedge clock);
        checkOutput("scoreboard drained", 16'(scoreboard.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
